mshr_noc_packetizer: RTL and testbench

- Sits directly downstream of the MSHR request arbiter.
- Takes the single arbitrated memory request, serializes it into NoC flits (header, address, optional data) on a valid/ready NoC output channel.
- Decodes returning NoC response packets into a one-cycle atomic response pulse (data + mshrid) back to the arbiter.
- One request packetizer FSM and one independent response depacketizer FSM.

---
 rtl/mshr_noc_packetizer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mshr_noc_packetizer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mshr_noc_packetizer.sv
// mshr_noc_packetizer
// Serializes one arbitrated MSHR request into NoC flits (header, address and
// optional store/AMO data) and turns returning NoC response packets into a
// single-cycle response pulse. The transmit and receive paths are independent.
// Optional build macro: MSHR_NOC_PACKETIZER_PERF_EN adds saturating packet
// counters perf_req_pkts / perf_resp_pkts.
module mshr_noc_packetizer #(
    parameter int FLIT_W   = 64,
    parameter int MSHRID_W = 8,
    parameter int PADDR_W  = 40,
    parameter int HOMEID_W = 30
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_type,
    input  logic [MSHRID_W-1:0] req_mshrid,
    input  logic [PADDR_W-1:0]  req_address,
    input  logic [2:0]          req_size,
    input  logic [HOMEID_W-1:0] req_homeid,
    input  logic [7:0]          req_write_mask,
    input  logic [63:0]         req_data_0,
    input  logic [63:0]         req_data_1,
    output logic                noc_out_val,
    input  logic                noc_out_rdy,
    output logic [FLIT_W-1:0]   noc_out_data,
    input  logic                noc_in_val,
    output logic                noc_in_rdy,
    input  logic [FLIT_W-1:0]   noc_in_data,
    output logic                resp_valid,
    output logic [MSHRID_W-1:0] resp_mshrid,
    output logic [63:0]         resp_data
`ifdef MSHR_NOC_PACKETIZER_PERF_EN
    ,
    output logic [31:0]         perf_req_pkts,
    output logic [31:0]         perf_resp_pkts
`endif
);

    typedef enum logic [2:0] {TX_IDLE, TX_HDR, TX_ADDR, TX_D0, TX_D1} tx_state_t;
    typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_DRAIN} rx_state_t;

    localparam logic [1:0] T_LOAD  = 2'd0;
    localparam logic [1:0] T_STORE = 2'd1;
    localparam logic [1:0] T_AMO   = 2'd2;

    // Header flit: destination tile, payload length, message type, mshrid.
    function automatic logic [FLIT_W-1:0] f_hdr(input logic [1:0]          t,
                                                 input logic [MSHRID_W-1:0] id,
                                                 input logic [HOMEID_W-1:0] hid);
        logic [FLIT_W-1:0] f;
        logic [7:0]        len;
        logic [7:0]        mt;
        case (t)
            T_STORE: begin len = 8'd2; mt = 8'd2; end
            T_AMO:   begin len = 8'd3; mt = 8'd3; end
            default: begin len = 8'd1; mt = 8'd1; end
        endcase
        f               = '0;
        f[63:50]        = hid[29:16];
        f[49:42]        = hid[15:8];
        f[41:34]        = hid[7:0];
        f[29:22]        = len;
        f[21:14]        = mt;
        f[6 +: MSHRID_W] = id;
        return f;
    endfunction

    // Address flit: address, size, and byte mask (mask forced to 0 for loads).
    function automatic logic [FLIT_W-1:0] f_addr(input logic [1:0]         t,
                                                  input logic [PADDR_W-1:0] a,
                                                  input logic [2:0]         sz,
                                                  input logic [7:0]         m);
        logic [FLIT_W-1:0] f;
        f                = '0;
        f[PADDR_W-1:0]   = a;
        f[42:40]         = sz;
        f[55:48]         = (t == T_LOAD) ? 8'd0 : m;
        return f;
    endfunction

    function automatic logic [31:0] f_sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    tx_state_t          r_tx_state;
    logic               r_req_ready;
    logic               r_noc_out_val;
    logic [FLIT_W-1:0]  r_noc_out_data;
    logic [1:0]         r_type;
    logic [PADDR_W-1:0] r_addr;
    logic [2:0]         r_size;
    logic [7:0]         r_mask;
    logic [63:0]        r_d0;
    logic [63:0]        r_d1;

    rx_state_t           r_rx_state;
    logic                r_noc_in_rdy;
    logic                r_resp_valid;
    logic [MSHRID_W-1:0] r_resp_mshrid;
    logic [63:0]         r_resp_data;
    logic [MSHRID_W-1:0] r_rx_id;
    logic [7:0]          r_rx_cnt;

    logic                w_req_hs;
    logic                w_tx_fire;
    logic                w_tx_last;
    logic [1:0]          w_type_n;
    logic                w_rx_fire;
    logic [7:0]          w_in_len;
    logic [MSHRID_W-1:0] w_in_id;

    assign w_req_hs  = req_valid && r_req_ready;
    assign w_tx_fire = r_noc_out_val && noc_out_rdy;
    assign w_type_n  = (req_type == 2'd3) ? T_LOAD : req_type;
    assign w_tx_last = w_tx_fire &&
                       (((r_tx_state == TX_ADDR) && (r_type == T_LOAD)) ||
                        ((r_tx_state == TX_D0)   && (r_type == T_STORE)) ||
                        (r_tx_state == TX_D1));

    assign w_rx_fire = noc_in_val && r_noc_in_rdy;
    assign w_in_len  = noc_in_data[29:22];
    assign w_in_id   = noc_in_data[6 +: MSHRID_W];

    // Capture the accepted request fields used by the later flits.
    always_ff @(posedge clk) begin
        if (w_req_hs) begin
            r_type <= w_type_n;
            r_addr <= req_address;
            r_size <= req_size;
            r_mask <= req_write_mask;
            r_d0   <= req_data_0;
            r_d1   <= req_data_1;
        end
    end

    // Request packetizer FSM: emits HDR, ADDR, D0, D1 holding each until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state     <= TX_IDLE;
            r_req_ready    <= 1'b0;
            r_noc_out_val  <= 1'b0;
            r_noc_out_data <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_req_hs) begin
                        r_req_ready    <= 1'b0;
                        r_noc_out_val  <= 1'b1;
                        r_noc_out_data <= f_hdr(w_type_n, req_mshrid, req_homeid);
                        r_tx_state     <= TX_HDR;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                TX_HDR: begin
                    if (w_tx_fire) begin
                        r_noc_out_data <= f_addr(r_type, r_addr, r_size, r_mask);
                        r_tx_state     <= TX_ADDR;
                    end
                end
                TX_ADDR: begin
                    if (w_tx_fire) begin
                        if (r_type == T_LOAD) begin
                            r_noc_out_val <= 1'b0;
                            r_req_ready   <= 1'b1;
                            r_tx_state    <= TX_IDLE;
                        end else begin
                            r_noc_out_data <= r_d0;
                            r_tx_state     <= TX_D0;
                        end
                    end
                end
                TX_D0: begin
                    if (w_tx_fire) begin
                        if (r_type == T_STORE) begin
                            r_noc_out_val <= 1'b0;
                            r_req_ready   <= 1'b1;
                            r_tx_state    <= TX_IDLE;
                        end else begin
                            r_noc_out_data <= r_d1;
                            r_tx_state     <= TX_D1;
                        end
                    end
                end
                TX_D1: begin
                    if (w_tx_fire) begin
                        r_noc_out_val <= 1'b0;
                        r_req_ready   <= 1'b1;
                        r_tx_state    <= TX_IDLE;
                    end
                end
                default: begin
                    r_noc_out_val <= 1'b0;
                    r_req_ready   <= 1'b0;
                    r_tx_state    <= TX_IDLE;
                end
            endcase
        end
    end

    // Response depacketizer FSM: first data flit becomes the response, the rest are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state    <= RX_HDR;
            r_noc_in_rdy  <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_mshrid <= '0;
            r_resp_data   <= '0;
            r_rx_id       <= '0;
            r_rx_cnt      <= '0;
        end else begin
            r_noc_in_rdy <= 1'b1;
            r_resp_valid <= 1'b0;
            if (w_rx_fire) begin
                case (r_rx_state)
                    RX_HDR: begin
                        if (w_in_len == 8'd0) begin
                            r_resp_valid  <= 1'b1;
                            r_resp_mshrid <= w_in_id;
                            r_resp_data   <= '0;
                        end else begin
                            r_rx_id    <= w_in_id;
                            r_rx_cnt   <= w_in_len - 8'd1;
                            r_rx_state <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        r_resp_valid  <= 1'b1;
                        r_resp_mshrid <= r_rx_id;
                        r_resp_data   <= noc_in_data[63:0];
                        r_rx_state    <= (r_rx_cnt == 8'd0) ? RX_HDR : RX_DRAIN;
                    end
                    RX_DRAIN: begin
                        r_rx_cnt <= r_rx_cnt - 8'd1;
                        if (r_rx_cnt == 8'd1) begin
                            r_rx_state <= RX_HDR;
                        end
                    end
                    default: r_rx_state <= RX_HDR;
                endcase
            end
        end
    end

`ifdef MSHR_NOC_PACKETIZER_PERF_EN
    logic [31:0] r_perf_req;
    logic [31:0] r_perf_resp;

    // Saturating counters of completed request packets and response pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_req  <= '0;
            r_perf_resp <= '0;
        end else begin
            if (w_tx_last)    r_perf_req  <= f_sat_inc(r_perf_req);
            if (r_resp_valid) r_perf_resp <= f_sat_inc(r_perf_resp);
        end
    end

    assign perf_req_pkts  = r_perf_req;
    assign perf_resp_pkts = r_perf_resp;
`endif

    assign req_ready    = r_req_ready;
    assign noc_out_val  = r_noc_out_val;
    assign noc_out_data = r_noc_out_data;
    assign noc_in_rdy   = r_noc_in_rdy;
    assign resp_valid   = r_resp_valid;
    assign resp_mshrid  = r_resp_mshrid;
    assign resp_data    = r_resp_data;

endmodule

// File: tb/tb_mshr_noc_packetizer.sv
// Testbench for mshr_noc_packetizer: table-driven response vectors plus
// hand-written request sequences with hand-computed flit values.
module tb_mshr_noc_packetizer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [7:0]  req_mshrid;
    logic [39:0] req_address;
    logic [2:0]  req_size;
    logic [29:0] req_homeid;
    logic [7:0]  req_write_mask;
    logic [63:0] req_data_0;
    logic [63:0] req_data_1;
    logic        noc_out_val;
    logic        noc_out_rdy;
    logic [63:0] noc_out_data;
    logic        noc_in_val;
    logic        noc_in_rdy;
    logic [63:0] noc_in_data;
    logic        resp_valid;
    logic [7:0]  resp_mshrid;
    logic [63:0] resp_data;

    int n_checks = 0;
    int n_err    = 0;

    mshr_noc_packetizer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_type       (req_type),
        .req_mshrid     (req_mshrid),
        .req_address    (req_address),
        .req_size       (req_size),
        .req_homeid     (req_homeid),
        .req_write_mask (req_write_mask),
        .req_data_0     (req_data_0),
        .req_data_1     (req_data_1),
        .noc_out_val    (noc_out_val),
        .noc_out_rdy    (noc_out_rdy),
        .noc_out_data   (noc_out_data),
        .noc_in_val     (noc_in_val),
        .noc_in_rdy     (noc_in_rdy),
        .noc_in_data    (noc_in_data),
        .resp_valid     (resp_valid),
        .resp_mshrid    (resp_mshrid),
        .resp_data      (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        val;
        logic [63:0] data;
        logic        ev;
        logic [7:0]  eid;
        logic [63:0] ed;
    } rx_vec_t;

    rx_vec_t tbl[22];

    function automatic logic [63:0] rh(input int len, input int id);
        return (64'(len) << 22) | (64'(id) << 6);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic rdy_pat(input int c);
        return ((c % 4) == 0) || ((c % 4) == 3);
    endfunction

    // Apply response rows lo..hi, one per clock, checking outputs after each edge.
    task automatic run_resp(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            noc_in_val  = tbl[i].val;
            noc_in_data = tbl[i].data;
            @(posedge clk); #1;
            chk($sformatf("rx%0d_valid", i), 64'(resp_valid), 64'(tbl[i].ev));
            chk($sformatf("rx%0d_mshrid", i), 64'(resp_mshrid), 64'(tbl[i].eid));
            chk($sformatf("rx%0d_data", i), resp_data, tbl[i].ed);
        end
        noc_in_val = 1'b0;
    endtask

    // Issue one request and collect its flits; called and returns at posedge+1.
    task automatic send_req(input string nm, input logic [1:0] t, input logic [7:0] id,
                            input logic [39:0] a, input logic [2:0] sz, input logic [29:0] hid,
                            input logic [7:0] m, input logic [63:0] d0, input logic [63:0] d1,
                            input bit toggle, input int n,
                            input logic [63:0] e0, input logic [63:0] e1,
                            input logic [63:0] e2, input logic [63:0] e3);
        logic [63:0] exp [4];
        logic [63:0] held_d;
        bit          held;
        int          cyc;
        int          k;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        chk({nm, "_idle_val"}, 64'(noc_out_val), 64'd0);
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_ready_wait"}, 64'(req_ready), 64'd1);
        req_type       = t;
        req_mshrid     = id;
        req_address    = a;
        req_size       = sz;
        req_homeid     = hid;
        req_write_mask = m;
        req_data_0     = d0;
        req_data_1     = d1;
        req_valid      = 1'b1;
        @(posedge clk); #1;
        req_valid   = 1'b0;
        noc_out_rdy = toggle ? rdy_pat(0) : 1'b1;
        chk({nm, "_hdr_next_cycle"}, 64'(noc_out_val), 64'd1);
        chk({nm, "_ready_low"}, 64'(req_ready), 64'd0);
        k = 0; cyc = 0; held = 1'b0;
        while (k < n && cyc < 40) begin
            if (noc_out_val && noc_out_rdy) begin
                chk($sformatf("%s_flit%0d", nm, k), noc_out_data, exp[k]);
                k++;
                held = 1'b0;
            end else if (noc_out_val) begin
                held   = 1'b1;
                held_d = noc_out_data;
            end else begin
                chk({nm, "_val_mid_packet"}, 64'(noc_out_val), 64'd1);
            end
            @(posedge clk); #1;
            cyc++;
            if (held) begin
                chk({nm, "_hold_val"}, 64'(noc_out_val), 64'd1);
                chk({nm, "_hold_data"}, noc_out_data, held_d);
            end
            noc_out_rdy = toggle ? rdy_pat(cyc) : 1'b1;
        end
        chk({nm, "_flit_count"}, 64'(k), 64'(n));
        chk({nm, "_ready_after_last"}, 64'(req_ready), 64'd1);
        chk({nm, "_val_after_last"}, 64'(noc_out_val), 64'd0);
        noc_out_rdy = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, rh(1, 8'h2A),       1'b0, 8'h00, 64'h0};
        tbl[1]  = '{1'b1, 64'hCAFE,           1'b1, 8'h2A, 64'hCAFE};
        tbl[2]  = '{1'b0, 64'h0,              1'b0, 8'h2A, 64'hCAFE};
        tbl[3]  = '{1'b0, 64'h0,              1'b0, 8'h2A, 64'hCAFE};
        tbl[4]  = '{1'b0, 64'h0,              1'b0, 8'h2A, 64'hCAFE};
        tbl[5]  = '{1'b1, rh(1, 7),           1'b0, 8'h2A, 64'hCAFE};
        tbl[6]  = '{1'b1, 64'hDEAD_BEEF,      1'b1, 8'h07, 64'hDEAD_BEEF};
        tbl[7]  = '{1'b1, rh(3, 4),           1'b0, 8'h07, 64'hDEAD_BEEF};
        tbl[8]  = '{1'b1, 64'h111,            1'b1, 8'h04, 64'h111};
        tbl[9]  = '{1'b1, 64'h222,            1'b0, 8'h04, 64'h111};
        tbl[10] = '{1'b1, 64'h333,            1'b0, 8'h04, 64'h111};
        tbl[11] = '{1'b1, rh(0, 9),           1'b1, 8'h09, 64'h0};
        tbl[12] = '{1'b0, 64'h0,              1'b0, 8'h09, 64'h0};
        tbl[13] = '{1'b1, rh(2, 3),           1'b0, 8'h09, 64'h0};
        tbl[14] = '{1'b0, 64'hFFFF,           1'b0, 8'h09, 64'h0};
        tbl[15] = '{1'b1, 64'h55,             1'b1, 8'h03, 64'h55};
        tbl[16] = '{1'b1, 64'h66,             1'b0, 8'h03, 64'h55};
        tbl[17] = '{1'b1, rh(1, 8'h15),       1'b0, 8'h03, 64'h55};
        tbl[18] = '{1'b1, 64'h77,             1'b1, 8'h15, 64'h77};
        tbl[19] = '{1'b1, rh(0, 1),           1'b1, 8'h01, 64'h0};
        tbl[20] = '{1'b1, rh(0, 2),           1'b1, 8'h02, 64'h0};
        tbl[21] = '{1'b0, 64'h0,              1'b0, 8'h02, 64'h0};

        rst_n = 1'b1;
        req_valid = 1'b0; req_type = 2'd0; req_mshrid = 8'd0; req_address = 40'd0;
        req_size = 3'd0; req_homeid = 30'd0; req_write_mask = 8'd0;
        req_data_0 = 64'd0; req_data_1 = 64'd0;
        noc_out_rdy = 1'b1; noc_in_val = 1'b0; noc_in_data = 64'd0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_noc_out_val", 64'(noc_out_val), 64'd0);
        chk("rst_noc_out_data", noc_out_data, 64'd0);
        chk("rst_noc_in_rdy", 64'(noc_in_rdy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_mshrid", 64'(resp_mshrid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_noc_in_rdy", 64'(noc_in_rdy), 64'd1);
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);

        // LOAD, rdy always high
        send_req("load", 2'd0, 8'd5, 40'h12_3456_7880, 3'd3, {14'd1, 8'd2, 8'd3}, 8'h00,
                 64'h0, 64'h0, 1'b0, 2,
                 64'h0004_080C_0040_4140, 64'h0000_0312_3456_7880, 64'h0, 64'h0);

        // AMO with rdy pattern 1,0,0,1
        send_req("amo", 2'd2, 8'd9, 40'h40, 3'd3, {14'd0, 8'd0, 8'd1}, 8'hFF,
                 64'hA, 64'hB, 1'b1, 4,
                 64'h0000_0004_00C0_C240, 64'h00FF_0300_0000_0040, 64'hA, 64'hB);

        // STORE concurrent with a response packet
        fork
            send_req("store", 2'd1, 8'd2, 40'h100, 3'd2, {14'd0, 8'd1, 8'd0}, 8'h0F,
                     64'h1111, 64'h0, 1'b0, 3,
                     64'h0000_0400_0080_8080, 64'h000F_0200_0000_0100, 64'h1111, 64'h0);
            run_resp(0, 4);
        join

        // Response sequences: len=1, len=3 with drop, len=0, gaps, back-to-back
        run_resp(5, 21);

        // Reset asserted while D0 is on the output
        req_type = 2'd1; req_mshrid = 8'd3; req_address = 40'h200; req_size = 3'd3;
        req_homeid = 30'd0; req_write_mask = 8'hF0; req_data_0 = 64'h5A5A; req_data_1 = 64'h0;
        noc_out_rdy = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        noc_out_rdy = 1'b0;
        chk("mid_d0_val", 64'(noc_out_val), 64'd1);
        chk("mid_d0_data", noc_out_data, 64'h5A5A);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_val", 64'(noc_out_val), 64'd0);
        chk("mid_rst_data", noc_out_data, 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        noc_out_rdy = 1'b1;

        // Fresh packet after reset: reserved type behaves as LOAD, mask suppressed
        send_req("rsv", 2'd3, 8'd1, 40'h8, 3'd0, 30'd0, 8'hFF,
                 64'h99, 64'h0, 1'b0, 2,
                 64'h0000_0000_0040_4040, 64'h0000_0000_0000_0008, 64'h0, 64'h0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
